// File: rtl/plic_lite.sv
// Lite platform-level interrupt controller: level gateways, priority arbiter with
// threshold, and a single claim/complete context on a simple request/ack bus.
module plic_lite #(
    parameter int unsigned NSRC   = 8,
    parameter int unsigned PRIO_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NSRC-1:0]   src,
    input  logic              bus_req,
    input  logic              bus_we,
    input  logic [23:0]       bus_addr,
    input  logic [31:0]       bus_wdata,
    output logic [31:0]       bus_rdata,
    output logic              bus_ack,
    output logic              irq_ext
);

    // Per-source state is indexed by source ID, so bit 0 does not exist.
    logic [NSRC:1]     r_s1, r_s2, r_pend, r_insvc, r_en;
    logic [PRIO_W-1:0] r_prio [1:NSRC];
    logic [PRIO_W-1:0] r_thr;
    logic              r_ack, r_irq;
    logic [31:0]       r_rdata;

    logic              w_accept, w_rd, w_wr;
    logic              w_prio_sel, w_sel_pend, w_sel_en, w_sel_thr, w_sel_cc;
    logic [9:0]        w_prio_idx;
    logic [4:0]        w_best_id, w_cmpl_id;
    logic [PRIO_W-1:0] w_best_prio;
    logic              w_claim, w_cmpl;
    logic [NSRC:1]     w_pend_nxt, w_insvc_nxt;
    logic [31:0]       w_rdata;
    logic              w_unused;

    assign w_accept   = bus_req & ~r_ack;
    assign w_rd       = w_accept & ~bus_we;
    assign w_wr       = w_accept & bus_we;
    assign w_prio_sel = (bus_addr[23:12] == 12'h000) && (bus_addr[1:0] == 2'b00);
    assign w_prio_idx = bus_addr[11:2];
    assign w_sel_pend = (bus_addr == 24'h001000);
    assign w_sel_en   = (bus_addr == 24'h002000);
    assign w_sel_thr  = (bus_addr == 24'h200000);
    assign w_sel_cc   = (bus_addr == 24'h200004);
    assign w_claim    = w_rd & w_sel_cc & (w_best_id != 5'd0);
    assign w_cmpl     = w_wr & w_sel_cc;
    assign w_cmpl_id  = bus_wdata[4:0];
    assign w_unused   = ^bus_wdata;

    // Ascending scan with strict '>' gives ties to the lowest ID and skips prio 0.
    always_comb begin
        w_best_id   = '0;
        w_best_prio = '0;
        for (int unsigned i = 1; i <= NSRC; i++) begin
            if (r_pend[i] && r_en[i] && (r_prio[i] > w_best_prio)) begin
                w_best_id   = 5'(i);
                w_best_prio = r_prio[i];
            end
        end
    end

    // Claim beats a same-edge gateway set; pending only re-arms once in-service is clear.
    always_comb begin
        w_pend_nxt  = r_pend;
        w_insvc_nxt = r_insvc;
        for (int unsigned i = 1; i <= NSRC; i++) begin
            if (w_claim && (w_best_id == 5'(i))) begin
                w_pend_nxt[i]  = 1'b0;
                w_insvc_nxt[i] = 1'b1;
            end else begin
                if (r_s2[i] && !r_pend[i] && !r_insvc[i])
                    w_pend_nxt[i] = 1'b1;
                if (w_cmpl && (w_cmpl_id == 5'(i)))
                    w_insvc_nxt[i] = 1'b0;
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        if (w_prio_sel) begin
            for (int unsigned i = 1; i <= NSRC; i++) begin
                if (w_prio_idx == 10'(i))
                    w_rdata = 32'(r_prio[i]);
            end
        end else if (w_sel_pend) begin
            w_rdata = 32'({r_pend, 1'b0});
        end else if (w_sel_en) begin
            w_rdata = 32'({r_en, 1'b0});
        end else if (w_sel_thr) begin
            w_rdata = 32'(r_thr);
        end else if (w_sel_cc) begin
            w_rdata = 32'(w_best_id);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1    <= '0;
            r_s2    <= '0;
            r_pend  <= '0;
            r_insvc <= '0;
            r_en    <= '0;
            r_thr   <= '0;
            r_ack   <= 1'b0;
            r_irq   <= 1'b0;
            r_rdata <= '0;
            for (int unsigned i = 1; i <= NSRC; i++)
                r_prio[i] <= '0;
        end else begin
            r_s1    <= src;
            r_s2    <= r_s1;
            r_pend  <= w_pend_nxt;
            r_insvc <= w_insvc_nxt;
            r_ack   <= w_accept;
            r_rdata <= w_rd ? w_rdata : '0;
            r_irq   <= (w_best_prio > r_thr);
            if (w_wr && w_sel_en)
                r_en <= bus_wdata[NSRC:1];
            if (w_wr && w_sel_thr)
                r_thr <= bus_wdata[PRIO_W-1:0];
            for (int unsigned i = 1; i <= NSRC; i++) begin
                if (w_wr && w_prio_sel && (w_prio_idx == 10'(i)))
                    r_prio[i] <= bus_wdata[PRIO_W-1:0];
            end
        end
    end

    assign bus_ack   = r_ack;
    assign bus_rdata = r_rdata;
    assign irq_ext   = r_irq;

endmodule

// File: doc/plic_lite.md
Name: plic_lite

Overview:
- Platform-level interrupt controller for core0. Responder on the D-bus; drives the core's irq_ext input. It is the source end of the external-interrupt line that the core consumes.
- Collects NSRC level-sensitive external sources (gpio pins in the top level) and passes each through a gateway.
- Arbitrates the pending sources by priority against a threshold and implements claim/complete for a single M-mode context.
- The D-bus interconnect decodes the base address. This block sees a 24-bit byte offset.

Parameters:
- NSRC, 8, number of sources; IDs 1..NSRC; ID 0 means "none"; max 31.
- PRIO_W, 3, priority width; priority 0 = never interrupts.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- src  in  NSRC  raw interrupt levels, asynchronous; src[i-1] is ID i
- bus_req  in  1  access request, held until bus_ack
- bus_we  in  1  1 = write
- bus_addr  in  24  byte offset, word aligned
- bus_wdata  in  32  write data
- bus_rdata  out  32  read data, valid while bus_ack=1
- bus_ack  out  1  one-cycle completion pulse
- irq_ext  out  1  registered interrupt request to core

Behaviour:
- Reset (asynchronous): all synchronizers, pending, in-service, priority, enable and threshold state clear to 0; irq_ext=0; bus_ack=0; bus_rdata=0.
- Synchronizer: each src bit passes through 2 flops. Gateway uses the 2nd flop (s2).
- Gateway, per ID i:
  - pending[i] sets when s2[i]=1, pending[i]=0 and inservice[i]=0.
  - A claim of ID i clears pending[i] and sets inservice[i] in the same edge.
  - A complete of ID i clears inservice[i], only if it was set. Otherwise the complete is ignored.
  - If the source is still high after complete, pending[i] re-sets on the next edge.
  - A source that deasserts after pending is set stays pending until claimed.
- Latency: src rises before edge E1. s2=1 after E2, pending=1 after E3, irq_ext=1 after E4.
- Arbiter (combinational):
  - Candidates are IDs with pending & enable & prio>0.
  - best_id = candidate with the highest priority; ties go to the lowest ID; 0 if there are no candidates.
  - irq_ext is registered as (prio[best_id] > threshold).
  - After a claim clears the last candidate, irq_ext falls on the edge after the claim.
- Register map (byte offsets):
  - 0x000000+4*i: priority[i], RW, low PRIO_W bits. i=0 is read 0 / write ignored.
  - 0x001000: pending, RO. Bit i = ID i; bit 0 reads 0.
  - 0x002000: enable, RW. Bit 0 is hardwired 0; bits above NSRC read 0.
  - 0x200000: threshold, RW, PRIO_W bits.
  - 0x200004: claim/complete.
    - Read returns best_id, ignoring threshold, and performs the claim atomically. If best_id=0, it returns 0 with no side effect.
    - Write takes wdata[4:0] as the ID to complete.
  - Unmapped or out-of-range offsets: read 0, write ignored, still acknowledged.
- Bus handshake:
  - A request is accepted on an edge where bus_req=1 and bus_ack=0.
  - bus_ack=1 on the following cycle only, with bus_rdata valid. Read latency is 1 cycle.
  - Write and register side effects take effect on the accept edge.
  - Claim side effects happen on the accept edge.
  - If the master holds bus_req through the ack cycle, that is not a second accept. A new accept may happen the cycle after the ack. Max throughput is 1 access per 2 cycles.
  - bus_rdata returns to 0 when bus_ack=0.
- Simultaneous events:
  - A claim and a gateway set for the same ID on the same edge: the claim wins. The ID ends inservice=1, pending=0.
  - A config write (enable/priority/threshold) and a claim cannot coincide, because there is one access per accept.
  - A complete for ID i on the same edge that s2[i]=1: inservice clears. pending sets one edge later.
- Reset mid-transaction: bus_ack and all state drop immediately. An in-flight access is lost; the master re-issues it.

Test Plan:
- Reset, then read every register -> all read 0; irq_ext=0; each access gets exactly one bus_ack pulse one cycle after accept.
- prio[3]=2, enable=0x08, threshold=0; raise src[2] -> pending=0x08 after 3 edges, irq_ext=1 after 4. Claim read returns 3 and pending=0; irq_ext falls the next edge. Source still high, no re-pend. Write complete=3 -> pending=0x08 again one edge later.
- prio[2]=5, prio[5]=5, prio[6]=7, enable=0x64, all three sources high -> successive claims return 6, 2, 5, then 0. The claim returning 0 changes no state.
- threshold=4, only ID 2 pending with prio 4 -> irq_ext=0, but a claim still returns 2. Set threshold=3 on another source's pend -> irq_ext=1.
- Complete write of ID 7 while not in service; write to pending at 0x001000; write priority[0]; access 0x300000 -> all ignored, reads return 0, every access acked.
- Pulse src[0] for 1 cycle, so it is captured only if it spans a sync edge. Held 3 cycles, then dropped -> pending stays set until claimed. Assert rst_n=0 mid-read -> bus_ack=0 and pending=0 immediately.
